// File: rtl/ahb_uart_arbiter.sv
// ahb_uart_arbiter
// Shares the single AHB UART bridge slave between two masters, m0 (core data
// port) and m1 (debug/loader port). One whole transaction is granted at a time
// with round-robin priority. The winner's request is forwarded to the slave.
// The slave's completion is registered and returned to the winner. A watchdog
// forces a release when the slave never completes.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   m_hsel/m_hwrite [1:0]     per-master request and write flag (bit i = master i)
//   m_haddr, m_hwdata         packed per master, master i in [i*W +: W]
//   m_hready [1:0]            one-cycle completion pulse to the owning master
//   m_hresp, m_herr [1:0]     captured slave response / timeout error, valid with m_hready
//   m_hrdata                  captured read data (shared), held until the next capture
//   s_hsel, s_hwrite,
//   s_haddr, s_hwdata         request forwarded to the UART bridge (zero outside BUSY)
//   s_hready, s_hresp,
//   s_hrdata                  slave completion, response/accept flag, read data
//   grant_o [1:0]             one-hot current owner (debug)
module ahb_uart_arbiter #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 64,
  parameter int CNT_W          = $clog2(TIMEOUT)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [1:0]                  m_hsel,
  input  logic [1:0]                  m_hwrite,
  input  logic [2*AHB_ADDR_WIDTH-1:0] m_haddr,
  input  logic [2*AHB_DATA_WIDTH-1:0] m_hwdata,
  output logic [1:0]                  m_hready,
  output logic [1:0]                  m_hresp,
  output logic [1:0]                  m_herr,
  output logic [AHB_DATA_WIDTH-1:0]   m_hrdata,
  output logic                        s_hsel,
  output logic                        s_hwrite,
  output logic [AHB_ADDR_WIDTH-1:0]   s_haddr,
  output logic [AHB_DATA_WIDTH-1:0]   s_hwdata,
  input  logic                        s_hready,
  input  logic                        s_hresp,
  input  logic [AHB_DATA_WIDTH-1:0]   s_hrdata,
  output logic [1:0]                  grant_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                    r_state;
  state_t                    w_next;
  logic [1:0]                r_grant;
  logic                      r_last;
  logic [CNT_W-1:0]          r_cnt;
  logic [1:0]                r_hready;
  logic [1:0]                r_hresp;
  logic [1:0]                r_herr;
  logic [AHB_DATA_WIDTH-1:0] r_hrdata;

  logic w_done;
  logic w_timeout;
  logic w_win;

  // A bare s_hresp (write accept) also ends the transaction.
  assign w_done    = s_hready | s_hresp;
  assign w_timeout = (r_cnt == LAST_CNT);

  // Lone requester wins; on a tie the master that did not win last time wins.
  assign w_win = (m_hsel == 2'b11) ? ~r_last : m_hsel[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    s_hsel   = 1'b0;
    s_hwrite = 1'b0;
    s_haddr  = '0;
    s_hwdata = '0;
    case (r_state)
      IDLE: begin
        if (|m_hsel) w_next = BUSY;
      end
      BUSY: begin
        s_hsel   = 1'b1;
        s_hwrite = r_grant[1] ? m_hwrite[1] : m_hwrite[0];
        s_haddr  = r_grant[1] ? m_haddr[2*AHB_ADDR_WIDTH-1:AHB_ADDR_WIDTH]
                              : m_haddr[AHB_ADDR_WIDTH-1:0];
        s_hwdata = r_grant[1] ? m_hwdata[2*AHB_DATA_WIDTH-1:AHB_DATA_WIDTH]
                              : m_hwdata[AHB_DATA_WIDTH-1:0];
        if (w_done || w_timeout) w_next = RELEASE;
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant bookkeeping, watchdog and the registered completion returned to
  // the owner. r_grant is one-hot, so it doubles as the per-master pulse mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_hready <= 2'b00;
      r_hresp  <= 2'b00;
      r_herr   <= 2'b00;
      r_hrdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|m_hsel) begin
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_last  <= w_win;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (w_done) begin
            // Completion beats the watchdog when both land on the same cycle.
            r_hready <= r_grant;
            r_hresp  <= s_hresp ? r_grant : 2'b00;
            r_herr   <= 2'b00;
            r_hrdata <= s_hready ? s_hrdata : '0;
          end else if (w_timeout) begin
            r_hready <= r_grant;
            r_hresp  <= 2'b00;
            r_herr   <= r_grant;
            r_hrdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RELEASE: begin
          r_hready <= 2'b00;
          r_hresp  <= 2'b00;
          r_herr   <= 2'b00;
          r_grant  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign m_hready = r_hready;
  assign m_hresp  = r_hresp;
  assign m_herr   = r_herr;
  assign m_hrdata = r_hrdata;
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_ahb_uart_arbiter.sv
// tb_ahb_uart_arbiter
// Self-checking bench for ahb_uart_arbiter (TIMEOUT=16). A bench-side slave
// answers after a chosen number of s_hsel cycles; a round-robin reference
// model predicts the owner and the returned completion of every transaction.
module tb_ahb_uart_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          rstn;
  logic [1:0]    m_hsel;
  logic [1:0]    m_hwrite;
  logic [2*AW-1:0] m_haddr;
  logic [2*DW-1:0] m_hwdata;
  logic [1:0]    m_hready;
  logic [1:0]    m_hresp;
  logic [1:0]    m_herr;
  logic [DW-1:0] m_hrdata;
  logic          s_hsel;
  logic          s_hwrite;
  logic [AW-1:0] s_haddr;
  logic [DW-1:0] s_hwdata;
  logic          s_hready;
  logic          s_hresp;
  logic [DW-1:0] s_hrdata;
  logic [1:0]    grant_o;

  int errors = 0;
  int checks = 0;
  int mLast  = 1;

  typedef struct packed {
    int          owner;
    int          hselCycles;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  hrdyRel;
    logic [1:0]  hresp;
    logic [1:0]  herr;
    logic [31:0] hrdata;
    logic [1:0]  hrdyAfter;
    logic [1:0]  grantAfter;
    logic        sselRel;
    logic        sselAfter;
    logic        ok;
  } obs_t;

  ahb_uart_arbiter #(
    .AHB_ADDR_WIDTH(AW),
    .AHB_DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .m_hsel(m_hsel),
    .m_hwrite(m_hwrite),
    .m_haddr(m_haddr),
    .m_hwdata(m_hwdata),
    .m_hready(m_hready),
    .m_hresp(m_hresp),
    .m_herr(m_herr),
    .m_hrdata(m_hrdata),
    .s_hsel(s_hsel),
    .s_hwrite(s_hwrite),
    .s_haddr(s_haddr),
    .s_hwdata(s_hwdata),
    .s_hready(s_hready),
    .s_hresp(s_hresp),
    .s_hrdata(s_hrdata),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_limit reached");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic setMaster(input int i, input bit sel, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
    m_hsel[i]          = sel;
    m_hwrite[i]        = wr;
    m_haddr[i*AW +: AW]  = a;
    m_hwdata[i*DW +: DW] = d;
  endtask

  task automatic doReset();
    rstn     = 1'b0;
    m_hsel   = '0;
    m_hwrite = '0;
    m_haddr  = '0;
    m_hwdata = '0;
    s_hready = 1'b0;
    s_hresp  = 1'b0;
    s_hrdata = '0;
    repeat (3) @(negedge clk);
    rstn  = 1'b1;
    mLast = 1;
    @(negedge clk);
  endtask

  // Bench-side slave: answers on the delay-th cycle of s_hsel (0 = never).
  // Records what the slave saw and what the masters got back.
  task automatic doTxn(input int delay, input bit useRdy, input bit useResp,
                       input logic [31:0] rdata, output obs_t o);
    int w;
    int c;
    o = '0;
    o.owner = -1;
    o.ok = 1'b1;
    w = 0;
    while (s_hsel !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (s_hsel !== 1'b1) begin
      o.ok = 1'b0;
    end else begin
      o.owner = (grant_o == 2'b10) ? 1 : ((grant_o == 2'b01) ? 0 : -1);
      o.wr    = s_hwrite;
      o.addr  = s_haddr;
      o.wdata = s_hwdata;
      c = 1;
      while (s_hsel === 1'b1 && c <= TO + 5) begin
        if (c == delay) begin
          s_hready = useRdy;
          s_hresp  = useResp;
          s_hrdata = rdata;
        end else begin
          s_hready = 1'b0;
          s_hresp  = 1'b0;
          s_hrdata = $urandom;
        end
        @(negedge clk);
        if (s_hsel === 1'b1) c++;
      end
      s_hready = 1'b0;
      s_hresp  = 1'b0;
      s_hrdata = '0;
      if (s_hsel === 1'b1) o.ok = 1'b0;
      o.hselCycles = c;
      o.sselRel    = s_hsel;
      o.hrdyRel    = m_hready;
      o.hresp      = m_hresp;
      o.herr       = m_herr;
      o.hrdata     = m_hrdata;
      @(negedge clk);
      o.hrdyAfter  = m_hready;
      o.grantAfter = grant_o;
      o.sselAfter  = s_hsel;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_hsel = '0; m_hwrite = '0; m_haddr = '0; m_hwdata = '0;
    s_hready = 1'b0; s_hresp = 1'b0; s_hrdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_hready, m_hresp, m_herr, grant_o, s_hsel, s_hwrite} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {m_hready, m_hresp, m_herr, grant_o, s_hsel, s_hwrite});
    end
    checks++;
    if (m_hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata got=%h exp=0", m_hrdata); end
    checks++;
    if ({s_haddr, s_hwdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_sbus got=%h exp=0", {s_haddr, s_hwdata}); end
    rstn = 1'b1;
    mLast = 1;
    @(negedge clk);
    checks++;
    if ({s_hsel, grant_o} !== 3'b0) begin errors++; $display("[TB] FAIL idle_no_req got=%b exp=0", {s_hsel, grant_o}); end
  endtask

  task automatic test_single_read();
    obs_t o;
    doReset();
    setMaster(0, 1, 0, 32'h4000_0004, 32'h0);
    doTxn(2, 1, 0, 32'h1, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    mLast = 0;
    checks++;
    if (o.ok !== 1'b1) begin errors++; $display("[TB] FAIL read_handshake got=%b exp=1", o.ok); end
    checks++;
    if (o.owner != 0 || o.addr !== 32'h4000_0004 || o.wr !== 1'b0) begin
      errors++; $display("[TB] FAIL read_fwd got owner=%0d addr=%h wr=%b exp owner=0 addr=40000004 wr=0", o.owner, o.addr, o.wr);
    end
    checks++;
    if (o.hselCycles != 2) begin errors++; $display("[TB] FAIL read_hsel_len got=%0d exp=2", o.hselCycles); end
    checks++;
    if (o.hrdyRel !== 2'b01 || o.herr !== 2'b00 || o.hresp !== 2'b00) begin
      errors++; $display("[TB] FAIL read_done got rdy=%b err=%b resp=%b exp rdy=01 err=00 resp=00", o.hrdyRel, o.herr, o.hresp);
    end
    checks++;
    if (o.hrdata !== 32'h1) begin errors++; $display("[TB] FAIL read_data got=%h exp=1", o.hrdata); end
    checks++;
    if (o.hrdyAfter !== 2'b00 || o.grantAfter !== 2'b00) begin
      errors++; $display("[TB] FAIL read_pulse got rdy=%b grant=%b exp 00/00", o.hrdyAfter, o.grantAfter);
    end
    checks++;
    if (m_hrdata !== 32'h1) begin errors++; $display("[TB] FAIL read_hold got=%h exp=1", m_hrdata); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    doReset();
    setMaster(0, 1, 1, 32'h4000_0000, 32'hA5);
    setMaster(1, 1, 1, 32'h4000_0008, 32'h5A);
    doTxn(1, 1, 0, 32'h0, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (o.ok !== 1'b1 || o.owner != 0 || o.wdata !== 32'hA5 || o.wr !== 1'b1) begin
      errors++; $display("[TB] FAIL simul_first got owner=%0d wdata=%h wr=%b exp owner=0 wdata=a5 wr=1", o.owner, o.wdata, o.wr);
    end
    checks++;
    if (o.hrdyRel !== 2'b01 || o.hrdyAfter !== 2'b00 || o.sselRel !== 1'b0 || o.sselAfter !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_first_gap got rdy=%b/%b hsel=%b/%b exp 01/00 0/0", o.hrdyRel, o.hrdyAfter, o.sselRel, o.sselAfter);
    end
    doTxn(1, 1, 0, 32'h0, o);
    setMaster(1, 0, 0, 32'h0, 32'h0);
    mLast = 1;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 1 || o.wdata !== 32'h5A || o.addr !== 32'h4000_0008) begin
      errors++; $display("[TB] FAIL simul_second got owner=%0d wdata=%h addr=%h exp owner=1 wdata=5a addr=40000008", o.owner, o.wdata, o.addr);
    end
    checks++;
    if (o.hrdyRel !== 2'b10 || o.hrdyAfter !== 2'b00) begin
      errors++; $display("[TB] FAIL simul_second_pulse got=%b/%b exp 10/00", o.hrdyRel, o.hrdyAfter);
    end
  endtask

  task automatic test_fairness();
    obs_t o;
    logic [31:0] dat [2];
    int prev;
    int expOwner [6] = '{0, 1, 0, 1, 0, 1};
    doReset();
    dat[0] = $urandom;
    dat[1] = $urandom;
    setMaster(0, 1, 1, 32'h100, dat[0]);
    setMaster(1, 1, 1, 32'h200, dat[1]);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      doTxn($urandom_range(1, 3), 1, 0, $urandom, o);
      checks++;
      if (o.ok !== 1'b1 || o.owner != expOwner[k] || o.owner == prev) begin
        errors++; $display("[TB] FAIL fair_owner[%0d] got=%0d exp=%0d", k, o.owner, expOwner[k]);
      end
      checks++;
      if (o.wdata !== dat[expOwner[k]]) begin
        errors++; $display("[TB] FAIL fair_wdata[%0d] got=%h exp=%h", k, o.wdata, dat[expOwner[k]]);
      end
      prev = o.owner;
      dat[expOwner[k]] = $urandom;
      setMaster(expOwner[k], 1, 1, expOwner[k] == 0 ? 32'h100 : 32'h200, dat[expOwner[k]]);
    end
    setMaster(0, 0, 0, 32'h0, 32'h0);
    setMaster(1, 0, 0, 32'h0, 32'h0);
    mLast = 1;
  endtask

  task automatic test_write_accept();
    obs_t o;
    setMaster(0, 1, 1, 32'h4000_0010, 32'h77);
    doTxn(1, 0, 1, 32'hDEAD_BEEF, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    mLast = 0;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 0) begin errors++; $display("[TB] FAIL wacc_owner got=%0d exp=0", o.owner); end
    checks++;
    if (o.hrdyRel !== 2'b01 || o.hresp !== 2'b01 || o.herr !== 2'b00) begin
      errors++; $display("[TB] FAIL wacc_done got rdy=%b resp=%b err=%b exp 01/01/00", o.hrdyRel, o.hresp, o.herr);
    end
    checks++;
    if (o.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL wacc_data got=%h exp=0", o.hrdata); end
  endtask

  task automatic test_timeout();
    obs_t o;
    doReset();
    setMaster(0, 1, 0, 32'h4000_0020, 32'h0);
    setMaster(1, 1, 0, 32'h4000_0024, 32'h0);
    doTxn(0, 0, 0, 32'h0, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (o.ok !== 1'b1 || o.owner != 0 || o.hselCycles != TO) begin
      errors++; $display("[TB] FAIL tmo_len got owner=%0d cycles=%0d exp owner=0 cycles=%0d", o.owner, o.hselCycles, TO);
    end
    checks++;
    if (o.hrdyRel !== 2'b01 || o.herr !== 2'b01 || o.hresp !== 2'b00 || o.hrdata !== 32'h0) begin
      errors++; $display("[TB] FAIL tmo_err got rdy=%b err=%b resp=%b data=%h exp 01/01/00/0", o.hrdyRel, o.herr, o.hresp, o.hrdata);
    end
    doTxn(3, 1, 0, 32'h0000_00C3, o);
    setMaster(1, 0, 0, 32'h0, 32'h0);
    mLast = 1;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 1 || o.herr !== 2'b00 || o.hrdata !== 32'hC3) begin
      errors++; $display("[TB] FAIL tmo_next got owner=%0d err=%b data=%h exp owner=1 err=00 data=c3", o.owner, o.herr, o.hrdata);
    end
  endtask

  task automatic test_done_last_cycle();
    obs_t o;
    setMaster(0, 1, 0, 32'h4000_0030, 32'h0);
    doTxn(TO, 1, 0, 32'h1234_5678, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    mLast = 0;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 0 || o.hselCycles != TO) begin
      errors++; $display("[TB] FAIL lastcyc_len got owner=%0d cycles=%0d exp owner=0 cycles=%0d", o.owner, o.hselCycles, TO);
    end
    checks++;
    if (o.hrdyRel !== 2'b01 || o.herr !== 2'b00 || o.hrdata !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL lastcyc_done got rdy=%b err=%b data=%h exp 01/00/12345678", o.hrdyRel, o.herr, o.hrdata);
    end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    int w;
    setMaster(1, 1, 1, 32'h4000_0040, 32'hBB);
    w = 0;
    while (s_hsel !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    checks++;
    if (s_hsel !== 1'b1 || grant_o !== 2'b10) begin
      errors++; $display("[TB] FAIL rstbusy_pre got hsel=%b grant=%b exp 1/10", s_hsel, grant_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({s_hsel, grant_o, m_hready, m_hresp, m_herr} !== 9'b0 || m_hrdata !== 32'h0 || s_hwdata !== 32'h0) begin
      errors++; $display("[TB] FAIL rstbusy_clear got ctrl=%b hrdata=%h hwdata=%h exp 0", {s_hsel, grant_o, m_hready, m_hresp, m_herr}, m_hrdata, s_hwdata);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mLast = 1;
    setMaster(0, 1, 0, 32'h4000_0044, 32'h0);
    doTxn(1, 1, 0, 32'h55, o);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    mLast = 0;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 0 || o.hrdyRel !== 2'b01) begin
      errors++; $display("[TB] FAIL rstbusy_rearb got owner=%0d rdy=%b exp owner=0 rdy=01", o.owner, o.hrdyRel);
    end
    doTxn(1, 1, 0, 32'h66, o);
    setMaster(1, 0, 0, 32'h0, 32'h0);
    mLast = 1;
    checks++;
    if (o.ok !== 1'b1 || o.owner != 1 || o.wdata !== 32'hBB) begin
      errors++; $display("[TB] FAIL rstbusy_reissue got owner=%0d wdata=%h exp owner=1 wdata=bb", o.owner, o.wdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit pend [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    bit rw [2];
    pend[0] = 0;
    pend[1] = 0;
    for (int k = 0; k < 14; k++) begin
      int win;
      int delay;
      int mode;
      bit rdy;
      bit rsp;
      bit tmo;
      logic [31:0] sdata;
      logic [1:0] oh;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          ra[i] = $urandom;
          rd[i] = $urandom;
          rw[i] = 1'($urandom_range(0, 1));
          setMaster(i, 1, rw[i], ra[i], rd[i]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        int i = $urandom_range(0, 1);
        pend[i] = 1;
        ra[i] = $urandom;
        rd[i] = $urandom;
        rw[i] = 1'($urandom_range(0, 1));
        setMaster(i, 1, rw[i], ra[i], rd[i]);
      end
      if (pend[0] && pend[1]) win = (mLast == 0) ? 1 : 0;
      else                    win = pend[1] ? 1 : 0;
      oh = (win == 1) ? 2'b10 : 2'b01;
      delay = $urandom_range(1, TO + 3);
      mode  = $urandom_range(0, 2);
      rdy   = (mode != 1);
      rsp   = (mode != 0);
      sdata = $urandom;
      tmo   = (delay > TO);
      doTxn(delay, rdy, rsp, sdata, o);
      checks++;
      if (o.ok !== 1'b1 || o.owner != win) begin
        errors++; $display("[TB] FAIL rnd_owner[%0d] got=%0d exp=%0d", k, o.owner, win);
      end
      checks++;
      if (o.addr !== ra[win] || o.wdata !== rd[win] || o.wr !== rw[win]) begin
        errors++; $display("[TB] FAIL rnd_fwd[%0d] got addr=%h wdata=%h wr=%b exp addr=%h wdata=%h wr=%b", k, o.addr, o.wdata, o.wr, ra[win], rd[win], rw[win]);
      end
      checks++;
      if (o.hselCycles != (tmo ? TO : delay)) begin
        errors++; $display("[TB] FAIL rnd_len[%0d] got=%0d exp=%0d", k, o.hselCycles, tmo ? TO : delay);
      end
      checks++;
      if (o.hrdyRel !== oh || o.herr !== (tmo ? oh : 2'b00) || o.hresp !== ((!tmo && rsp) ? oh : 2'b00)) begin
        errors++; $display("[TB] FAIL rnd_done[%0d] got rdy=%b err=%b resp=%b exp rdy=%b err=%b resp=%b", k, o.hrdyRel, o.herr, o.hresp, oh, tmo ? oh : 2'b00, (!tmo && rsp) ? oh : 2'b00);
      end
      checks++;
      if (o.hrdata !== ((!tmo && rdy) ? sdata : 32'h0)) begin
        errors++; $display("[TB] FAIL rnd_data[%0d] got=%h exp=%h", k, o.hrdata, (!tmo && rdy) ? sdata : 32'h0);
      end
      checks++;
      if (o.hrdyAfter !== 2'b00 || o.grantAfter !== 2'b00) begin
        errors++; $display("[TB] FAIL rnd_pulse[%0d] got rdy=%b grant=%b exp 00/00", k, o.hrdyAfter, o.grantAfter);
      end
      mLast = win;
      pend[win] = 0;
      setMaster(win, 0, 0, 32'h0, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        doTxn(1, 1, 0, 32'h0, o);
        setMaster(i, 0, 0, 32'h0, 32'h0);
        mLast = i;
        checks++;
        if (o.ok !== 1'b1 || o.owner != i) begin
          errors++; $display("[TB] FAIL rnd_drain got=%0d exp=%0d", o.owner, i);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write_accept();
    test_timeout();
    test_done_last_cycle();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
